// File: rtl/apply_iteration_sync.sv
// apply_iteration_sync: per-lane 1-cycle vertex register plus all-core iteration-end barrier (pipelined AND tree) broadcasting iteration_end, iteration_id, convergence and finish
module apply_iteration_sync #(
  parameter int V_ID_WIDTH      = 20,
  parameter int CORE_NUM        = 32,
  parameter int ITERATION_WIDTH = 6,
  parameter int MAX_ITERATION   = 63,
  parameter int TREE_REG_EVERY  = 2
) (
  input  logic                             clk,
  input  logic [CORE_NUM-1:0]              rst,
  input  logic [CORE_NUM*V_ID_WIDTH-1:0]   front_active_v_id,
  input  logic [CORE_NUM-1:0]              front_active_v_updated,
  input  logic [CORE_NUM-1:0]              front_active_v_valid,
  input  logic [CORE_NUM-1:0]              front_iteration_end,
  input  logic [CORE_NUM-1:0]              front_iteration_end_valid,
  output logic [CORE_NUM*V_ID_WIDTH-1:0]   active_v_id,
  output logic [CORE_NUM-1:0]              active_v_updated,
  output logic [CORE_NUM-1:0]              active_v_valid,
  output logic [CORE_NUM-1:0]              iteration_end,
  output logic [CORE_NUM-1:0]              iteration_end_valid,
  output logic [ITERATION_WIDTH-1:0]       iteration_id,
  output logic                             acc_converged,
  output logic                             acc_finish
);
  localparam int LEVELS = $clog2(CORE_NUM);
  localparam int N2 = 1 << LEVELS;
  localparam int NR = (N2 > 1) ? N2 - 1 : 1;
  localparam logic [ITERATION_WIDTH-1:0] MAX_I = ITERATION_WIDTH'(MAX_ITERATION);
  typedef enum logic [1:0] {RUN, BCAST, DONE} state_t;
  state_t state_q, state_d;
  logic [CORE_NUM*V_ID_WIDTH-1:0] id_q, id_d;
  logic [CORE_NUM-1:0] vld_q, vld_d, upd_q, upd_d, seen_q, seen_d, set_v, end_q;
  logic [2*N2-1:1] node;
  logic [NR:1] tree_q, tree_d;
  logic [ITERATION_WIDTH-1:0] iteration_id_q, iteration_id_d, iter_inc;
  logic any_upd_q, any_upd_d, acc_converged_q, acc_converged_d, all_seen, bcast, in_or;
  function automatic logic is_reg(input int k);
    int d = 0;
    for (int x = k; x > 1; x >>= 1) d++;
    return ((LEVELS - d) % TREE_REG_EVERY == 0) || (k == 1);
  endfunction
  always_comb begin
    vld_d = front_active_v_valid & ~rst;
    upd_d = front_active_v_updated & vld_d;
    id_d = '0;
    for (int i = 0; i < CORE_NUM; i++)
      id_d[i*V_ID_WIDTH +: V_ID_WIDTH] = vld_d[i] ? front_active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH] : '0;
  end
  // Heap-indexed AND tree: node k = node 2k & node 2k+1, leaves at N2.., root at 1.
  // Padding leaves read as 1; registered nodes are cleared on broadcast so stale 1s cannot retrigger.
  always_comb begin
    node = '0;
    tree_d = '0;
    for (int i = 0; i < N2; i++) node[N2 + i] = (i < CORE_NUM) ? seen_q[i] : 1'b1;
    for (int k = N2 - 1; k >= 1; k--) begin
      tree_d[k] = (rst[0] || bcast) ? 1'b0 : node[2*k] & node[2*k+1];
      node[k] = is_reg(k) ? tree_q[k] : node[2*k] & node[2*k+1];
    end
  end
  assign all_seen = node[1];
  assign in_or = |(front_active_v_valid & front_active_v_updated);
  always_comb begin
    bcast = state_q == BCAST;
    iter_inc = iteration_id_q + ITERATION_WIDTH'(1);
    state_d = (state_q == RUN) ? (all_seen ? BCAST : RUN) :
              bcast ? ((!any_upd_q || iter_inc == MAX_I) ? DONE : RUN) : DONE;
    set_v = (state_q == DONE) ? '0 : front_iteration_end_valid & front_iteration_end;
    seen_d = (set_v | (bcast ? '0 : seen_q)) & ~rst;
    any_upd_d = bcast ? in_or : (state_q == RUN) ? (any_upd_q | in_or) : any_upd_q;
    iteration_id_d = bcast ? iter_inc : iteration_id_q;
    acc_converged_d = bcast ? !any_upd_q : acc_converged_q;
  end
  always_ff @(posedge clk) begin
    id_q <= id_d;
    vld_q <= vld_d;
    upd_q <= upd_d;
    tree_q <= tree_d;
    if (rst[0]) begin
      state_q <= RUN;
      seen_q <= '0;
      any_upd_q <= 1'b0;
      iteration_id_q <= '0;
      acc_converged_q <= 1'b0;
      end_q <= '0;
    end else begin
      state_q <= state_d;
      seen_q <= seen_d;
      any_upd_q <= any_upd_d;
      iteration_id_q <= iteration_id_d;
      acc_converged_q <= acc_converged_d;
      end_q <= {CORE_NUM{bcast}};
    end
  end
  assign active_v_id = id_q;
  assign active_v_updated = upd_q;
  assign active_v_valid = vld_q;
  assign iteration_end = end_q;
  assign iteration_end_valid = end_q;
  assign iteration_id = iteration_id_q;
  assign acc_converged = acc_converged_q;
  assign acc_finish = state_q == DONE;
endmodule

// File: doc/apply_iteration_sync.md
Name: apply_iteration_sync

Overview:
Per-core apply-stage output register with a global iteration-end barrier. Each core lane forwards its active-vertex stream with one cycle of latency. Per-core iteration-end pulses are latched in sticky flags and AND-reduced through a pipelined tree of configurable depth. Once every core has ended, the block broadcasts a one-cycle synchronous iteration_end to all lanes, advances the iteration counter, and detects convergence or the iteration limit.

Parameters:
V_ID_WIDTH, 20, vertex id width
CORE_NUM, 32, number of core lanes; any value ≥1, not restricted to a power of two
ITERATION_WIDTH, 6, iteration counter width
MAX_ITERATION, 63, iteration count at which acc_finish asserts
TREE_REG_EVERY, 2, AND-tree levels between pipeline registers (≥1)

Ports:
clk  in  1  clock
rst  in  CORE_NUM  synchronous active-high reset. rst[i] resets lane i; rst[0] also resets the shared tree, FSM and counters
front_active_v_id  in  CORE_NUM*V_ID_WIDTH  per-lane vertex id
front_active_v_updated  in  CORE_NUM  vertex value changed this iteration
front_active_v_valid  in  CORE_NUM  vertex qualifier
front_iteration_end  in  CORE_NUM  core finished current iteration
front_iteration_end_valid  in  CORE_NUM  qualifier for front_iteration_end
active_v_id  out  CORE_NUM*V_ID_WIDTH  registered vertex id
active_v_updated  out  CORE_NUM  registered updated flag
active_v_valid  out  CORE_NUM  registered valid
iteration_end  out  CORE_NUM  global iteration end, identical on all lanes
iteration_end_valid  out  CORE_NUM  qualifier, identical on all lanes
iteration_id  out  ITERATION_WIDTH  number of completed iterations
acc_converged  out  1  last completed iteration produced no updates
acc_finish  out  1  accelerator done; sticky

Behaviour:
- Reset values: all outputs are 0. Sticky flags, tree registers, update flag and iteration counter are 0. FSM is in RUN.
- Vertex path, lane i, one cycle of latency:
  - If rst[i] or !front_active_v_valid[i]: id, updated and valid are cleared to 0.
  - Otherwise the inputs are registered and valid=1.
  - This path runs in every FSM state, including DONE.
- Sticky flag seen[i]:
  - Set when front_iteration_end_valid[i] && front_iteration_end[i].
  - A valid pulse with end=0 has no effect.
  - Cleared in the BROADCAST cycle. If a set occurs in that same cycle, set wins.
- AND tree:
  - levels = clog2(CORE_NUM). Missing leaves are tied to 1.
  - A register stage follows every TREE_REG_EVERY levels, and one follows the final level if it is not already registered.
  - Tree latency L = ceil(levels / TREE_REG_EVERY) cycles after seen. For CORE_NUM=1, L=0 and all_seen = seen[0].
  - All tree registers are synchronously cleared in the BROADCAST cycle so that stale 1s cannot retrigger.
- Update flag any_upd:
  - Set when any lane has front_active_v_valid && front_active_v_updated, in RUN only.
  - In the BROADCAST cycle the flag is consumed, then reset to that cycle's input OR, which counts toward the next iteration.
- FSM:
  - RUN: when all_seen=1, go to BROADCAST.
  - BROADCAST (1 cycle): on the next edge, iteration_end and iteration_end_valid are all-ones for exactly one cycle. iteration_id increments. acc_converged is set to !any_upd. If !any_upd, or the incremented iteration_id equals MAX_ITERATION, go to DONE; otherwise go to RUN.
  - DONE: acc_finish=1 and is held. Iteration-end inputs are ignored and no further broadcasts occur. Only rst[0] leaves DONE.
- Latency: the last core's end pulse at edge t produces iteration_end at edge t+2+L. With the defaults, L=3, so the broadcast lands at t+5.
- In cycles without a broadcast, iteration_end and iteration_end_valid are 0.
- iteration_id does not wrap: DONE is reached at MAX_ITERATION, which must satisfy MAX_ITERATION ≤ 2^ITERATION_WIDTH−1.
- Reset mid-operation:
  - rst[0] aborts any state and returns the block to RUN with all counters cleared.
  - rst[i] for i>0 clears only lane i's vertex registers and seen[i].

Test Plan:
- Reset: assert rst all-ones for 2 cycles → all outputs 0, iteration_id=0, FSM in RUN.
- Vertex passthrough: lane 5 gets id=0x1234, updated=1, valid=1 at cycle 10 → lane 5 outputs id=0x1234, updated=1, valid=1 at cycle 11. Lane 5 valid=0 at cycle 11 → id=0, valid=0 at cycle 12.
- Staggered ends with updates: lanes 0..31 pulse end at cycles 0..31, and one update occurs at cycle 3 → a single all-lane iteration_end at cycle 36 (31+5); iteration_id=1, acc_converged=0, FSM back in RUN.
- Barrier holds: 31 lanes end and lane 17 never does → iteration_end stays 0 for 200 cycles. Lane 17 ends at cycle 200 → broadcast at cycle 205.
- Convergence: an iteration completes with no updated vertices → the broadcast cycle sets acc_converged=1, acc_finish=1 one cycle later and held; further end pulses produce no broadcast.
- Limit and reset: MAX_ITERATION=3, with updates every iteration → acc_finish after the 3rd broadcast with iteration_id=3. Asserting rst[0] mid-collection (10 lanes seen) then completing all lanes → exactly one broadcast, and only after all 32 lanes pulse again.
